seq_step_controller: RTL and testbench
======================================

// Module: seq_step_controller
// PURPOSE
//  Sequences the lab's two-flip-flop a/b -> y/z state machine (DUT) from a programmed stimulus list.
//  Forces DUT into a known state, then per step: drive a/b, wait settle, sample y/z, pulse DUT clock.
//  Checks y/z against an internal golden model; counts mismatches. Sits between the bench/board switches and the DUT.
// PARAMETERS
//  DEPTH       16  max stimulus steps held (power of 2)
//  SETTLE_CYC  8   clk cycles per settle/clock phase; covers DUT gate+FF propagation (>= 1)
//  CNT_W       5   width of mismatch_cnt (saturating)
// PORTS
//  clk           in   1               system clock, rising edge
//  rst           in   1               synchronous, active-high reset
//  wr_en         in   1               write stimulus entry (ignored while busy)
//  wr_idx        in   $clog2(DEPTH)   entry index
//  wr_ab         in   2               {a,b} for that entry
//  len           in   $clog2(DEPTH)+1 steps to run, sampled at start; 0 = init only
//  start         in   1               1-cycle pulse, accepted only in IDLE
//  busy          out  1               high from accepted start until DONE
//  done          out  1               1-cycle pulse at run end
//  dut_a, dut_b  out  1 each          DUT inputs
//  dut_clk       out  1               DUT clock; idle low; DUT updates on its falling edge
//  dut_y, dut_z  in   1 each          DUT outputs
//  mismatch_cnt  out  CNT_W           steps where {y,z} != golden, saturates at all-ones
//  fail_valid    out  1               a mismatch occurred this run
//  first_fail    out  $clog2(DEPTH)   index of first mismatching step (valid when fail_valid)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, golden q1=q2=0, stimulus RAM contents undefined.
//  States: IDLE -> INIT_HI -> INIT_LO -> [APPLY -> SETTLE -> SAMPLE -> CLK_HI -> CLK_LO]*len -> DONE -> IDLE.
//  start in IDLE: latch len, clear mismatch_cnt/fail_valid/first_fail, busy=1.
//  INIT: dut_a=1, dut_b=0; dut_clk high SETTLE_CYC, then low SETTLE_CYC. Forces q1=1,q2=0; golden loaded same.
//  APPLY (1 cycle): drive {dut_a,dut_b}=entry[step]. SETTLE: hold SETTLE_CYC cycles.
//  SAMPLE (1 cycle): golden y=q1, z=~q1|(b&~q2); compare with dut_y/dut_z.
//  CLK_HI: dut_clk=1 for SETTLE_CYC. CLK_LO: dut_clk=0, golden updates on entry:
//   q1'=a|(b&~q2); q2'=q1&~q1'. Holds SETTLE_CYC, then step++.
//  After last CLK_LO (step==len): DONE, done=1 one cycle, busy=0, dut_a/dut_b hold last values.
//  len > DEPTH: clamped to DEPTH. Step index wraps never (terminates at len).
//  start while busy: ignored. wr_en while busy: ignored (RAM read-stable during run).
//  Simultaneous start and wr_en in IDLE: write lands, start reads new contents next cycle.
//  rst mid-run: immediate IDLE, dut_clk=0, dut_a=dut_b=0, counters cleared; no done pulse.
//  mismatch_cnt saturates at 2^CNT_W-1; first_fail latched only on first mismatch.
// CONFIGURATION
//  SEQ_STOP_ON_FAIL_EN defined: on first mismatch go SAMPLE -> DONE (no further DUT clocks); done pulses.
//  Not defined: run always completes all len steps.
// STRUCTURE
//  Package seq_ctrl_pkg: state enum, golden_next()/golden_out() functions, SETTLE counter width helper.
//  Sub-module seq_golden_model: 2-bit golden state (q1,q2) with load-init, step and output compare.
//  Top holds FSM, settle counter, stimulus RAM, result registers.
// TESTING
//  T1 reset: rst=1 2 cycles -> all outputs 0, busy=0, dut_clk=0.
//  T2 program {00,01,01}, len=3, correct DUT -> samples yz=10,01,01; mismatch_cnt=0, fail_valid=0, done 1 pulse.
//  T3 same, DUT model with z stuck-0 -> mismatch at steps 1,2; mismatch_cnt=2, first_fail=1.
//  T4 T3 with SEQ_STOP_ON_FAIL_EN -> done after step 1 sample; exactly 2 dut_clk falling edges total (init+step0).
//  T5 assert rst during step 1 CLK_HI -> next cycle IDLE, dut_clk=0, no done; fresh start runs normally.
//  T6 len=0 -> init only, done after INIT_LO; len=DEPTH+1 -> exactly DEPTH steps executed.

Source files
------------

// File: rtl/seq_step_controller_pkg.sv
// Shared state codes, golden-model equations and counter sizing for the
// seq_step_controller slice.
package seq_ctrl_pkg;

   localparam logic [3:0] ST_IDLE    = 4'd0;
   localparam logic [3:0] ST_INIT_HI = 4'd1;
   localparam logic [3:0] ST_INIT_LO = 4'd2;
   localparam logic [3:0] ST_APPLY   = 4'd3;
   localparam logic [3:0] ST_SETTLE  = 4'd4;
   localparam logic [3:0] ST_SAMPLE  = 4'd5;
   localparam logic [3:0] ST_CLK_HI  = 4'd6;
   localparam logic [3:0] ST_CLK_LO  = 4'd7;
   localparam logic [3:0] ST_DONE    = 4'd8;

   // q is {q1,q2}; result is {y,z}
   function automatic logic [1:0] golden_out(input logic [1:0] q, input logic b);
      return {q[1], ~q[1] | (b & ~q[0])};
   endfunction

   function automatic logic [1:0] golden_next(input logic [1:0] q, input logic a, input logic b);
      logic q1n;
      q1n = a | (b & ~q[0]);
      return {q1n, q[1] & ~q1n};
   endfunction

   // phase counter reloads with cyc-1, so it only has to hold that value
   function automatic int settle_cnt_w(input int cyc);
      return (cyc <= 2) ? 1 : $clog2(cyc);
   endfunction

endpackage

// File: rtl/seq_step_controller_if.sv
// Host-side programming/status bus of seq_step_controller.
interface seq_step_controller_if #(
   parameter int DEPTH = 16,
   parameter int CNT_W = 5
);
   localparam int AW = $clog2(DEPTH);

   logic             wr_en;
   logic [AW-1:0]    wr_idx;
   logic [1:0]       wr_ab;
   logic [AW:0]      len;
   logic             start;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] mismatch_cnt;
   logic             fail_valid;
   logic [AW-1:0]    first_fail;

   modport master (output wr_en, wr_idx, wr_ab, len, start,
                   input  busy, done, mismatch_cnt, fail_valid, first_fail);
   modport slave  (input  wr_en, wr_idx, wr_ab, len, start,
                   output busy, done, mismatch_cnt, fail_valid, first_fail);
endinterface

// File: rtl/seq_step_controller_golden.sv
// Two-flip-flop golden model of the lab DUT: init load, per-step update on the
// DUT clock fall, and live compare of its {y,z} against the DUT pins.
module seq_golden_model
   import seq_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic load_init_i,
   input  logic step_en_i,
   input  logic a_i,
   input  logic b_i,
   input  logic dut_y_i,
   input  logic dut_z_i,
   output logic mismatch_o
);
   logic [1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (load_init_i)    q_d = 2'b10;
      else if (step_en_i) q_d = golden_next(q_q, a_i, b_i);
   end

   always_ff @(posedge clk) begin
      if (rst) q_q <= 2'b00;
      else     q_q <= q_d;
   end

   assign mismatch_o = golden_out(q_q, b_i) != {dut_y_i, dut_z_i};
endmodule

// File: rtl/seq_step_controller.sv
// Stimulus sequencer/checker for the lab a/b -> y/z state machine.
// Optional macro SEQ_STOP_ON_FAIL_EN ends the run at the first mismatching sample.
module seq_step_controller
   import seq_ctrl_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int SETTLE_CYC = 8,
   parameter int CNT_W      = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   seq_step_controller_if.slave  hif,
   output logic                  dut_a,
   output logic                  dut_b,
   output logic                  dut_clk,
   input  logic                  dut_y,
   input  logic                  dut_z
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = settle_cnt_w(SETTLE_CYC);
   localparam logic [CW-1:0] SET_V = CW'(SETTLE_CYC - 1);
   localparam logic [AW:0]   MAX_LEN = (AW + 1)'(DEPTH);

   logic [1:0]       mem [DEPTH];
   logic [3:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [AW:0]      step_q, step_d, len_q, len_d;
   logic [1:0]       ab_q, ab_d;
   logic             clk_q, busy_q, done_q;
   logic [CNT_W-1:0] mcnt_q, mcnt_d;
   logic             fv_q, fv_d;
   logic [AW-1:0]    ff_q, ff_d;
   logic             cnt_zero, load_init, step_en, mism;

   assign cnt_zero = (cnt_q == '0);

   seq_golden_model u_golden (
      .clk(clk), .rst(rst), .load_init_i(load_init), .step_en_i(step_en),
      .a_i(ab_q[1]), .b_i(ab_q[0]), .dut_y_i(dut_y), .dut_z_i(dut_z), .mismatch_o(mism)
   );

   // RAM is frozen for the whole run so APPLY always reads what was programmed
   always_ff @(posedge clk) begin
      if (hif.wr_en && state_q == ST_IDLE) mem[hif.wr_idx] <= hif.wr_ab;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_zero ? cnt_q : cnt_q - 1'b1;
      step_d    = step_q;
      len_d     = len_q;
      ab_d      = ab_q;
      mcnt_d    = mcnt_q;
      fv_d      = fv_q;
      ff_d      = ff_q;
      load_init = 1'b0;
      step_en   = 1'b0;
      case (state_q)
         ST_IDLE: if (hif.start) begin
            state_d = ST_INIT_HI;
            cnt_d   = SET_V;
            len_d   = (hif.len > MAX_LEN) ? MAX_LEN : hif.len;
            step_d  = '0;
            ab_d    = 2'b10;
            mcnt_d  = '0;
            fv_d    = 1'b0;
            ff_d    = '0;
         end
         ST_INIT_HI: if (cnt_zero) begin
            state_d   = ST_INIT_LO;
            cnt_d     = SET_V;
            load_init = 1'b1;
         end
         ST_INIT_LO: if (cnt_zero) state_d = (len_q == '0) ? ST_DONE : ST_APPLY;
         ST_APPLY: begin
            ab_d    = mem[step_q[AW-1:0]];
            state_d = ST_SETTLE;
            cnt_d   = SET_V;
         end
         ST_SETTLE: if (cnt_zero) state_d = ST_SAMPLE;
         ST_SAMPLE: begin
            state_d = ST_CLK_HI;
            cnt_d   = SET_V;
            if (mism) begin
               mcnt_d = (&mcnt_q) ? mcnt_q : mcnt_q + 1'b1;
               if (!fv_q) begin
                  fv_d = 1'b1;
                  ff_d = step_q[AW-1:0];
               end
`ifdef SEQ_STOP_ON_FAIL_EN
               state_d = ST_DONE;
`endif
            end
         end
         ST_CLK_HI: if (cnt_zero) begin
            state_d = ST_CLK_LO;
            cnt_d   = SET_V;
            step_en = 1'b1;
         end
         ST_CLK_LO: if (cnt_zero) begin
            step_d  = step_q + 1'b1;
            state_d = (step_q + 1'b1 == len_q) ? ST_DONE : ST_APPLY;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         step_q  <= '0;
         len_q   <= '0;
         ab_q    <= '0;
         clk_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         mcnt_q  <= '0;
         fv_q    <= 1'b0;
         ff_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         step_q  <= step_d;
         len_q   <= len_d;
         ab_q    <= ab_d;
         clk_q   <= (state_d == ST_INIT_HI) || (state_d == ST_CLK_HI);
         busy_q  <= (state_d != ST_IDLE) && (state_d != ST_DONE);
         done_q  <= (state_d == ST_DONE);
         mcnt_q  <= mcnt_d;
         fv_q    <= fv_d;
         ff_q    <= ff_d;
      end
   end

   assign dut_a            = ab_q[1];
   assign dut_b            = ab_q[0];
   assign dut_clk          = clk_q;
   assign hif.busy         = busy_q;
   assign hif.done         = done_q;
   assign hif.mismatch_cnt = mcnt_q;
   assign hif.fail_valid   = fv_q;
   assign hif.first_fail   = ff_q;
endmodule

// File: tb/tb_seq_step_controller.sv
// Randomized scoreboard bench for seq_step_controller with an emulated lab DUT
// that can carry output faults.
module tb_seq_step_controller;
   localparam int DEPTH = 16;
   localparam int SETTLE = 8;
   localparam int CNT_W = 5;
   localparam int AW = $clog2(DEPTH);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seq_step_controller_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) hif();
   logic dut_a, dut_b, dut_clk, dut_y, dut_z;

   seq_step_controller #(.DEPTH(DEPTH), .SETTLE_CYC(SETTLE), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .hif(hif),
      .dut_a(dut_a), .dut_b(dut_b), .dut_clk(dut_clk), .dut_y(dut_y), .dut_z(dut_z)
   );

   // lab device: two FFs on the falling dut_clk edge; fault 1=z stuck0, 2=y stuck1, 3=z inverted
   logic q1 = 1'b0, q2 = 1'b0;
   int   fault = 0;
   int   edges = 0;
   always @(negedge dut_clk) begin
      q1 <= dut_a | (dut_b & ~q2);
      q2 <= q1 & ~(dut_a | (dut_b & ~q2));
      edges <= edges + 1;
   end
   always_comb begin
      logic zt;
      zt    = ~q1 | (dut_b & ~q2);
      dut_y = (fault == 2) ? 1'b1 : q1;
      dut_z = (fault == 1) ? 1'b0 : (fault == 3) ? ~zt : zt;
   end

   typedef struct {
      int cnt;
      bit fv;
      int ff;
      int edges;
      int base;
   } exp_t;
   exp_t sb[$];
   int   tests = 0, fails = 0;

   function automatic exp_t ref_model(input logic [1:0] ent [DEPTH], input int len, input int flt);
      exp_t e;
      int   n;
      bit   s1, s2, a, b, gy, gz, dy, dz, n1;
      e.cnt = 0; e.fv = 0; e.ff = 0; e.edges = 1; e.base = 0;
      n  = (len > DEPTH) ? DEPTH : len;
      s1 = 1; s2 = 0;
      for (int i = 0; i < n; i++) begin
         a  = ent[i][1];
         b  = ent[i][0];
         gy = s1;
         gz = !s1 || (b && !s2);
         dy = (flt == 2) ? 1'b1 : gy;
         dz = (flt == 1) ? 1'b0 : (flt == 3) ? !gz : gz;
         if (dy != gy || dz != gz) begin
            if (e.cnt < (1 << CNT_W) - 1) e.cnt++;
            if (!e.fv) begin
               e.fv = 1;
               e.ff = i;
            end
`ifdef SEQ_STOP_ON_FAIL_EN
            return e;
`endif
         end
         n1 = a || (b && !s2);
         s2 = s1 && !n1;
         s1 = n1;
         e.edges++;
      end
      return e;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // monitor: owns every comparison
   bit rst_prev = 1'b0;
   int wait_cyc = 0;
   always @(negedge clk) begin
      exp_t e;
      if (rst_prev) begin
         chk("reset_outputs", {hif.busy, hif.done, dut_clk, dut_a, dut_b, hif.fail_valid,
                               (hif.mismatch_cnt != 0), (hif.first_fail != 0)}, 0);
         sb.delete();
         wait_cyc = 0;
      end else if (hif.done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("mismatch_cnt", int'(hif.mismatch_cnt), e.cnt);
            chk("fail_valid", int'(hif.fail_valid), int'(e.fv));
            if (e.fv) chk("first_fail", int'(hif.first_fail), e.ff);
            chk("dut_clk_falls", edges - e.base, e.edges);
            chk("busy_at_done", int'(hif.busy), 0);
         end
         wait_cyc = 0;
      end else if (sb.size() != 0) begin
         wait_cyc++;
         if (wait_cyc > 3000) begin
            chk("done_timeout", 0, 1);
            void'(sb.pop_front());
            wait_cyc = 0;
         end
      end
      rst_prev = rst;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input logic [1:0] ent [DEPTH], input int len, input int flt, input bit do_rst);
      exp_t e;
      fault = flt;
      for (int i = 0; i < DEPTH - 1; i++) begin
         hif.wr_en = 1'b1; hif.wr_idx = AW'(i); hif.wr_ab = ent[i];
         tick();
      end
      // last entry written in the same cycle as start
      hif.wr_idx = AW'(DEPTH - 1); hif.wr_ab = ent[DEPTH-1];
      hif.len = (AW + 1)'(len); hif.start = 1'b1;
      e = ref_model(ent, len, flt);
      e.base = edges;
      sb.push_back(e);
      tick();
      hif.start = 1'b0;
      // write while busy must be ignored
      hif.wr_idx = '0; hif.wr_ab = ~ent[0];
      tick();
      hif.wr_en = 1'b0;
      if (do_rst) begin
         for (int c = 0; c < 3000 && !((edges - e.base) == 2 && dut_clk); c++) tick();
         rst = 1'b1;
         tick();
         rst = 1'b0;
      end
      for (int c = 0; c < 3000 && hif.busy; c++) tick();
      tick(); tick();
   endtask

   initial begin
      logic [1:0] ent [DEPTH];
      hif.wr_en = 1'b0; hif.wr_idx = '0; hif.wr_ab = '0; hif.len = '0; hif.start = 1'b0;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick();

      for (int i = 0; i < DEPTH; i++) ent[i] = 2'b00;
      ent[1] = 2'b01; ent[2] = 2'b01;
      run(ent, 3, 0, 1'b0);
      run(ent, 3, 1, 1'b0);

      for (int i = 0; i < DEPTH; i++) ent[i] = 2'($urandom);
      run(ent, 5, 0, 1'b1);
      run(ent, 5, 0, 1'b0);

      run(ent, 0, 0, 1'b0);
      run(ent, DEPTH + 1, 0, 1'b0);
      run(ent, DEPTH + 1, 3, 1'b0);

      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < DEPTH; i++) ent[i] = 2'($urandom);
         run(ent, int'($urandom_range(0, DEPTH + 1)), int'($urandom_range(0, 3)), 1'b0);
      end

      repeat (5) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
